wb_grf: RTL and testbench
=========================

// Module: wb_grf
// PURPOSE
//   Write-back stage plus general register file for the 5-stage MIPS pipeline.
//   - Consumes the W-stage pipeline register outputs.
//   - Selects and extends the write-back data.
//   - Writes the 32x32 GRF and serves the two D-stage read ports.
//   - Exports the W-stage write data and address for the hazard/forwarding unit.
//   - Counts retired instructions.
// PARAMETERS
//   CNT_W     32            width of retired-instruction counter
//   PC_INIT   32'h0000_3000 PC value meaning "pipeline still in reset"; the retire counter ignores it
// PORTS
//   Clock       in   1   rising-edge clock
//   Reset       in   1   asynchronous, active-low reset (0 = reset)
//   IR_W        in   32  W-stage instruction word
//   A3_W        in   5   W-stage destination register; 0 = no write
//   PC4_W       in   32  W-stage PC+4
//   AO_W        in   32  W-stage ALU result / memory address
//   DR_W        in   32  W-stage raw data-memory word
//   A1          in   5   D-stage read address, port 1
//   A2          in   5   D-stage read address, port 2
//   RD1         out  32  read data, port 1
//   RD2         out  32  read data, port 2
//   WD_W        out  32  selected write-back data (combinational)
//   RegWrite_W  out  1   1 when A3_W != 0
//   RetireCnt   out  CNT_W  retired-instruction count
// BEHAVIOUR
//   Reset (Reset=0, async)
//     - All registers 1..31 <= 0.
//     - RetireCnt <= 0.
//     - RD1/RD2 read 0 while in reset.
//   Write-data select (combinational; op = IR_W[31:26], fn = IR_W[5:0])
//     - lw  0x23: WD_W = DR_W.
//     - lb  0x20 / lbu 0x24: byte DR_W[8*AO_W[1:0] +: 8], sign-/zero-extended.
//     - lh  0x21 / lhu 0x25: half DR_W[16*AO_W[1] +: 16], sign-/zero-extended.
//       AO_W[0] is ignored.
//     - jal 0x03, or op 0x00 with fn 0x09 (jalr): WD_W = PC4_W + 4, modulo 2^32.
//     - All other opcodes: WD_W = AO_W.
//   Register write
//     - On posedge Clock when Reset=1 and A3_W != 0: GRF[A3_W] <= WD_W.
//     - Writes to $0 are discarded; $0 always reads 0.
//   Read ports
//     - Combinational array reads; A1 == 0 or A2 == 0 gives 0.
//   Retire counter
//     - On posedge, RetireCnt += 1 when IR_W != 0 and PC4_W != PC_INIT.
//     - Wraps to 0 at 2^CNT_W.
//     - Bubbles (IR_W = 0) are not counted.
//   Latency
//     - A write is visible in the array on the cycle after the edge that commits it.
//     - Internal bypass: see CONFIGURATION.
//   Simultaneous events
//     - A1 == A2 == A3_W: both ports see identical data.
//     - Reset asserted mid-write: the write is lost; the register stays 0.
// CONFIGURATION
//   WB_BYPASS_EN defined
//     - If RegWrite_W=1 and A1 == A3_W, RD1 = WD_W in the same cycle; same rule for A2 -> RD2.
//     - Write-then-read in one cycle therefore returns the new value.
//   WB_BYPASS_EN undefined
//     - RD1/RD2 return array contents only.
//     - The D-stage forwarding mux must select WD_W for an A3_W match.
// TESTING
//   1 Reset=0 mid-run, with GRF[5] = 32'h1234 -> RD1 (A1=5) = 0 and RetireCnt = 0 immediately, without waiting for a clock edge.
//   2 IR_W=lb, DR_W=32'h80FF_7F01, AO_W[1:0]=3, A3_W=8 -> GRF[8] = 32'hFFFF_FF80.
//     Same stimulus with lbu -> GRF[8] = 32'h0000_0080.
//     lh with AO_W[1:0]=1 -> GRF[8] = 32'h0000_7F01.
//   3 IR_W=jal, PC4_W=32'h0000_3010, A3_W=31 -> GRF[31] = 32'h0000_3014.
//     Same stimulus with A3_W=0 -> no write, and RD of $0 = 0.
//   4 A3_W=9, AO_W=32'hDEAD_BEEF, A1=9 in the same cycle:
//     - With WB_BYPASS_EN: RD1 = DEADBEEF before the edge.
//     - Without WB_BYPASS_EN: RD1 = old value before the edge and DEADBEEF after it.
//   5 10 valid instructions with 3 interleaved bubbles (IR_W=0) -> RetireCnt = 10.
//     With CNT_W=4, 17 valid instructions -> RetireCnt = 1 (wrap).
//   6 A1=A2=A3_W=4 with a write of 32'h5 -> RD1 = RD2 = 32'h5 after the edge.

Source files
------------

// File: rtl/wb_grf.sv
// rtl/wb_grf.sv - MIPS write-back stage, 32x32 register file and retire counter
// Optional same-cycle write-to-read bypass: define WB_BYPASS_EN.
module wb_grf #(
    parameter int          CNT_W   = 32,
    parameter logic [31:0] PC_INIT = 32'h0000_3000
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [31:0]      IR_W,
    input  logic [4:0]       A3_W,
    input  logic [31:0]      PC4_W,
    input  logic [31:0]      AO_W,
    input  logic [31:0]      DR_W,
    input  logic [4:0]       A1,
    input  logic [4:0]       A2,
    output logic [31:0]      RD1,
    output logic [31:0]      RD2,
    output logic [31:0]      WD_W,
    output logic             RegWrite_W,
    output logic [CNT_W-1:0] RetireCnt
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] FN_JALR    = 6'h09;

    logic [5:0]  op;
    logic [5:0]  fn;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] grf [32];
    logic [31:0] arr1;
    logic [31:0] arr2;

    assign op         = IR_W[31:26];
    assign fn         = IR_W[5:0];
    assign RegWrite_W = (A3_W != 5'd0);

    // Sub-word loads pick the lane by address; AO_W[0] is ignored for halves.
    assign ld_byte = DR_W[8*AO_W[1:0] +: 8];
    assign ld_half = AO_W[1] ? DR_W[31:16] : DR_W[15:0];

    always_comb begin
        WD_W = AO_W;
        case (op)
            OP_LW:      WD_W = DR_W;
            OP_LB:      WD_W = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:     WD_W = {24'd0, ld_byte};
            OP_LH:      WD_W = {{16{ld_half[15]}}, ld_half};
            OP_LHU:     WD_W = {16'd0, ld_half};
            OP_JAL:     WD_W = PC4_W + 32'd4;
            OP_SPECIAL: if (fn == FN_JALR) WD_W = PC4_W + 32'd4;
            default:    WD_W = AO_W;
        endcase
    end

    // Entry 0 is reset and never written, so it always holds zero.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 32; i++) grf[i] <= 32'd0;
        end else if (RegWrite_W) begin
            grf[A3_W] <= WD_W;
        end
    end

    assign arr1 = (A1 == 5'd0) ? 32'd0 : grf[A1];
    assign arr2 = (A2 == 5'd0) ? 32'd0 : grf[A2];

    always_comb begin
`ifdef WB_BYPASS_EN
        RD1 = (RegWrite_W && (A1 == A3_W)) ? WD_W : arr1;
        RD2 = (RegWrite_W && (A2 == A3_W)) ? WD_W : arr2;
`else
        RD1 = arr1;
        RD2 = arr2;
`endif
        if (!Reset) begin
            RD1 = 32'd0;
            RD2 = 32'd0;
        end
    end

    // Bubbles and the reset-time PC do not count as retired instructions.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            RetireCnt <= '0;
        end else if ((IR_W != 32'd0) && (PC4_W != PC_INIT)) begin
            RetireCnt <= RetireCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_grf.sv
// tb/tb_wb_grf.sv - directed self-checking bench for wb_grf
module tb_wb_grf;

    logic        Clock;
    logic        Reset;
    logic [31:0] IR_W;
    logic [4:0]  A3_W;
    logic [31:0] PC4_W;
    logic [31:0] AO_W;
    logic [31:0] DR_W;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] WD_W;
    logic        RegWrite_W;
    logic [31:0] RetireCnt;
    logic [31:0] s_rd1;
    logic [31:0] s_rd2;
    logic [31:0] s_wd;
    logic        s_rw;
    logic [3:0]  s_cnt;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] I_LB   = {6'h20, 26'd0};
    localparam logic [31:0] I_LBU  = {6'h24, 26'd0};
    localparam logic [31:0] I_LH   = {6'h21, 26'd0};
    localparam logic [31:0] I_JAL  = {6'h03, 26'd0};
    localparam logic [31:0] I_ADDU = 32'h0000_0021;

    wb_grf dut (
        .Clock(Clock), .Reset(Reset), .IR_W(IR_W), .A3_W(A3_W), .PC4_W(PC4_W),
        .AO_W(AO_W), .DR_W(DR_W), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .WD_W(WD_W), .RegWrite_W(RegWrite_W), .RetireCnt(RetireCnt)
    );

    wb_grf #(.CNT_W(4)) dut4 (
        .Clock(Clock), .Reset(Reset), .IR_W(IR_W), .A3_W(A3_W), .PC4_W(PC4_W),
        .AO_W(AO_W), .DR_W(DR_W), .A1(A1), .A2(A2), .RD1(s_rd1), .RD2(s_rd2),
        .WD_W(s_wd), .RegWrite_W(s_rw), .RetireCnt(s_cnt)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_write(input logic [31:0] ir, input logic [31:0] ao,
                            input logic [31:0] dr, input logic [31:0] pc4,
                            input logic [4:0] a3);
        IR_W = ir; AO_W = ao; DR_W = dr; PC4_W = pc4; A3_W = a3;
        tick();
        IR_W = 32'd0; A3_W = 5'd0;
    endtask

    task automatic test_reset();
        A1 = 5'd5; A2 = 5'd31;
        #1;
        total++; if (RD1 !== 32'd0) begin bad++; $display("FAIL reset_rd1 got=%h exp=%h", RD1, 32'd0); end
        total++; if (RD2 !== 32'd0) begin bad++; $display("FAIL reset_rd2 got=%h exp=%h", RD2, 32'd0); end
        total++; if (RetireCnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", RetireCnt); end
        total++; if (RegWrite_W !== 1'b0) begin bad++; $display("FAIL reset_regwrite got=%b exp=0", RegWrite_W); end
    endtask

    task automatic test_mid_reset();
        do_write(I_ADDU, 32'h0000_1234, 32'd0, 32'h0000_3008, 5'd5);
        A1 = 5'd5;
        #1;
        total++; if (RD1 !== 32'h0000_1234) begin bad++; $display("FAIL pre_reset_rd1 got=%h exp=%h", RD1, 32'h1234); end
        Reset = 1'b0;
        #1;
        total++; if (RD1 !== 32'd0) begin bad++; $display("FAIL mid_reset_rd1 got=%h exp=0", RD1); end
        total++; if (RetireCnt !== 32'd0) begin bad++; $display("FAIL mid_reset_cnt got=%0d exp=0", RetireCnt); end
        total++; if (s_cnt !== 4'd0) begin bad++; $display("FAIL mid_reset_cnt4 got=%0d exp=0", s_cnt); end
        IR_W = I_ADDU; AO_W = 32'h0000_ABCD; A3_W = 5'd5; PC4_W = 32'h0000_300C;
        tick();
        Reset = 1'b1; IR_W = 32'd0; A3_W = 5'd0;
        #1;
        total++; if (RD1 !== 32'd0) begin bad++; $display("FAIL write_in_reset got=%h exp=0", RD1); end
    endtask

    task automatic test_subword();
        IR_W = I_LB; DR_W = 32'h80FF_7F01; AO_W = 32'h0000_0003; A3_W = 5'd8; PC4_W = 32'h0000_3010;
        #1;
        total++; if (WD_W !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_wd got=%h exp=%h", WD_W, 32'hFFFF_FF80); end
        do_write(I_LB, 32'h0000_0003, 32'h80FF_7F01, 32'h0000_3010, 5'd8);
        A1 = 5'd8; #1;
        total++; if (RD1 !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_grf got=%h exp=%h", RD1, 32'hFFFF_FF80); end
        do_write(I_LBU, 32'h0000_0003, 32'h80FF_7F01, 32'h0000_3014, 5'd8);
        #1;
        total++; if (RD1 !== 32'h0000_0080) begin bad++; $display("FAIL lbu_grf got=%h exp=%h", RD1, 32'h80); end
        do_write(I_LH, 32'h0000_0001, 32'h80FF_7F01, 32'h0000_3018, 5'd8);
        #1;
        total++; if (RD1 !== 32'h0000_7F01) begin bad++; $display("FAIL lh_grf got=%h exp=%h", RD1, 32'h7F01); end
    endtask

    task automatic test_jal();
        do_write(I_JAL, 32'h0000_0000, 32'd0, 32'h0000_3010, 5'd31);
        A2 = 5'd31; #1;
        total++; if (RD2 !== 32'h0000_3014) begin bad++; $display("FAIL jal_grf got=%h exp=%h", RD2, 32'h3014); end
        IR_W = I_JAL; PC4_W = 32'h0000_3020; A3_W = 5'd0;
        #1;
        total++; if (RegWrite_W !== 1'b0) begin bad++; $display("FAIL jal_a3z_regwrite got=%b exp=0", RegWrite_W); end
        total++; if (WD_W !== 32'h0000_3024) begin bad++; $display("FAIL jal_wd got=%h exp=%h", WD_W, 32'h3024); end
        tick();
        IR_W = 32'd0; A1 = 5'd0; #1;
        total++; if (RD1 !== 32'd0) begin bad++; $display("FAIL zero_reg got=%h exp=0", RD1); end
        total++; if (RD2 !== 32'h0000_3014) begin bad++; $display("FAIL jal_keep got=%h exp=%h", RD2, 32'h3014); end
    endtask

    task automatic test_bypass();
        do_write(I_ADDU, 32'h1111_1111, 32'd0, 32'h0000_3030, 5'd9);
        IR_W = 32'd0; AO_W = 32'hDEAD_BEEF; A3_W = 5'd9; A1 = 5'd9;
        #1;
        total++; if (RegWrite_W !== 1'b1) begin bad++; $display("FAIL byp_regwrite got=%b exp=1", RegWrite_W); end
        total++; if (WD_W !== 32'hDEAD_BEEF) begin bad++; $display("FAIL byp_wd got=%h exp=%h", WD_W, 32'hDEAD_BEEF); end
`ifdef WB_BYPASS_EN
        total++; if (RD1 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL byp_before got=%h exp=%h", RD1, 32'hDEAD_BEEF); end
`else
        total++; if (RD1 !== 32'h1111_1111) begin bad++; $display("FAIL byp_before got=%h exp=%h", RD1, 32'h1111_1111); end
`endif
        tick();
        A3_W = 5'd0; #1;
        total++; if (RD1 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL byp_after got=%h exp=%h", RD1, 32'hDEAD_BEEF); end
    endtask

    task automatic test_same_addr();
        A1 = 5'd4; A2 = 5'd4;
        do_write(32'd0, 32'h0000_0005, 32'd0, 32'h0000_3040, 5'd4);
        #1;
        total++; if (RD1 !== 32'h5) begin bad++; $display("FAIL same_rd1 got=%h exp=5", RD1); end
        total++; if (RD2 !== 32'h5) begin bad++; $display("FAIL same_rd2 got=%h exp=5", RD2); end
    endtask

    task automatic test_retire();
        Reset = 1'b0; #2; Reset = 1'b1;
        for (int i = 0; i < 13; i++) begin
            IR_W  = (i == 3 || i == 7 || i == 11) ? 32'd0 : I_ADDU;
            PC4_W = 32'h0000_3004 + 32'(4 * i);
            A3_W  = 5'd0;
            tick();
        end
        IR_W = 32'd0; #1;
        total++; if (RetireCnt !== 32'd10) begin bad++; $display("FAIL retire_bubbles got=%0d exp=10", RetireCnt); end
        total++; if (s_cnt !== 4'd10) begin bad++; $display("FAIL retire_bubbles4 got=%0d exp=10", s_cnt); end
        IR_W = I_ADDU; PC4_W = 32'h0000_3000;
        tick(); tick();
        IR_W = 32'd0; #1;
        total++; if (RetireCnt !== 32'd10) begin bad++; $display("FAIL retire_pcinit got=%0d exp=10", RetireCnt); end
        Reset = 1'b0; #2; Reset = 1'b1;
        for (int i = 0; i < 17; i++) begin
            IR_W = I_ADDU; PC4_W = 32'h0000_3100 + 32'(4 * i);
            tick();
        end
        IR_W = 32'd0; #1;
        total++; if (RetireCnt !== 32'd17) begin bad++; $display("FAIL retire_17 got=%0d exp=17", RetireCnt); end
        total++; if (s_cnt !== 4'd1) begin bad++; $display("FAIL retire_wrap got=%0d exp=1", s_cnt); end
    endtask

    initial begin
        Reset = 1'b0; IR_W = 32'd0; A3_W = 5'd0; PC4_W = 32'h0000_3000;
        AO_W = 32'd0; DR_W = 32'd0; A1 = 5'd0; A2 = 5'd0;
        test_reset();
        #10;
        Reset = 1'b1;
        tick();
        test_mid_reset();
        test_subword();
        test_jal();
        test_bypass();
        test_same_addr();
        test_retire();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
